sbox_engine: RTL and testbench

Parametrised, sequential SubBytes/InvSubBytes unit for the AES datapath. It accepts a 128-bit state and a direction bit over a valid/ready handshake and substitutes all 16 bytes through LANES shared S-box lanes over 16/LANES cycles. It then holds the result until the consumer accepts it. It generalises the combinational per-byte substitution block: the lane count is selectable, it is time-multiplexed, and it is flow-controlled, so area can be traded against latency.

---
 rtl/sbox_engine.sv | 166 ++++++++++++++++
 tb/tb_sbox_engine.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_engine.sv
// sbox_engine: time-multiplexed AES SubBytes / InvSubBytes.
// LANES shared S-box lanes, valid/ready handshake on both sides.
module sbox_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_dir,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int NCYC = 16 / LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 &&
      LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("sbox_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          dir_q;
  logic [7:0]    src [16];
  logic [7:0]    res [16];
  logic [7:0]    in_b [16];

  logic [3:0]    base;
  logic [3:0]    lane_idx [LANES];
  logic [7:0]    lane_out [LANES];

  // GF(2^8) multiply by x, modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  // x^254 = x^-1 for x != 0; maps 00 to 00 on its own
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] aff(input logic [7:0] b);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      y[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^
             b[(i+6)%8] ^ b[(i+7)%8];
    end
    return y ^ 8'h63;
  endfunction

  function automatic logic [7:0] iaff(input logic [7:0] b);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      y[i] = b[(i+2)%8] ^ b[(i+5)%8] ^ b[(i+7)%8];
    end
    return y ^ 8'h05;
  endfunction

  // one inverter per lane, shared by both directions
  function automatic logic [7:0] sub(
    input logic [7:0] x,
    input logic       inv
  );
    logic [7:0] g;
    g = ginv(inv ? iaff(x) : x);
    return inv ? g : aff(g);
  endfunction

  for (genvar k = 0; k < 16; k++) begin : g_bytes
    assign in_b[k] = in_state[127-8*k -: 8];
    assign out_state[127-8*k -: 8] = res[k];
  end

  assign base = 4'(int'(cnt) * LANES);

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign lane_idx[j] = base + 4'(j);
    assign lane_out[j] = sub(src[lane_idx[j]], dir_q);
  end

  // control FSM, operand capture and result write-back
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt       <= '0;
      dir_q     <= 1'b0;
      src       <= '{default: '0};
      res       <= '{default: '0};
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            src      <= in_b;
            dir_q    <= in_dir;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          for (int j = 0; j < LANES; j++) begin
            res[lane_idx[j]] <= lane_out[j];
          end
          if (cnt == LAST) begin
            cnt       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_engine.sv
// tb_sbox_engine: three lane widths driven in lockstep,
// table-based reference model and per-instance scoreboards.
module tb_sbox_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         in_valid;
  logic         in_dir;
  logic [127:0] in_state;
  logic         out_ready = 1'b0;
  logic [2:0]   rdy;
  logic [2:0]   ov;
  logic [127:0] os0, os1, os2;
  logic [127:0] osv [3];

  assign osv[0] = os0;
  assign osv[1] = os1;
  assign osv[2] = os2;

  localparam int NC [3] = '{4, 16, 1};
  localparam logic [127:0] KAT_IN  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] KAT_OUT = 128'h63cab7040953d051cd60e0e7ba70e18c;

  sbox_engine #(.LANES(4)) u_l4 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(rdy[0]),
    .in_dir(in_dir), .in_state(in_state),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_state(os0)
  );

  sbox_engine #(.LANES(1)) u_l1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(rdy[1]),
    .in_dir(in_dir), .in_state(in_state),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_state(os1)
  );

  sbox_engine #(.LANES(16)) u_l16 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(rdy[2]),
    .in_dir(in_dir), .in_state(in_state),
    .out_valid(ov[2]), .out_ready(out_ready),
    .out_state(os2)
  );

  typedef struct {
    logic [127:0] d;
    int           t;
  } exp_t;

  exp_t q [3][$];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int or_mode = 1;

  logic [7:0]   fwd_t [256];
  logic [7:0]   inv_t [256];
  logic [2:0]   pv = '0;
  logic [2:0]   pend = '0;
  logic         prev_or = 1'b0;
  logic [127:0] ps [3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    checks++;
    $display("FAIL %s: got timeout/absent expected event", nm);
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] r, x, y;
    r = '0; x = a; y = b;
    while (y != 0) begin
      if (y[0]) r ^= x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    return 8'((b << k) | (b >> (8 - k)));
  endfunction

  // S-box built from its definition: brute-force inverse, rotation affine
  task automatic build_tables();
    logic [7:0] iv, xb;
    for (int x = 0; x < 256; x++) begin
      xb = 8'(x);
      iv = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++)
          if (gm(xb, 8'(y)) == 8'h01) iv = 8'(y);
      end
      fwd_t[x] = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^
                 rotl(iv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] s,
                                           input logic d);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      b = s[127-8*k -: 8];
      r[127-8*k -: 8] = d ? inv_t[b] : fwd_t[b];
    end
    return r;
  endfunction

  // out_ready policy: 0 = hold low, 1 = hold high, else random
  always @(posedge clk) begin
    #1;
    case (or_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 9) < 7);
    endcase
  end

  // monitor: latency, backpressure stability, data scoreboard
  always @(negedge clk) begin
    if (!reset_n) begin
      pv = '0;
      pend = '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (pend[i]) chk("in_ready_after_xfer", 128'(rdy[i]), 128'(1));
        pend[i] = 1'b0;
        if (ov[i] && !pv[i]) begin
          if (q[i].size() == 0) fail("spurious_out_valid");
          else chk("latency", 128'(cyc - q[i][0].t), 128'(NC[i]));
        end
        if (pv[i] && !prev_or) begin
          chk("hold_valid", 128'(ov[i]), 128'(1));
          chk("hold_state", osv[i], ps[i]);
        end
        if (ov[i]) chk("in_ready_busy", 128'(rdy[i]), 128'(0));
        if (ov[i] && out_ready) begin
          if (q[i].size() == 0) fail("unexpected_xfer");
          else begin
            chk("out_state", osv[i], q[i][0].d);
            void'(q[i].pop_front());
          end
          pend[i] = 1'b1;
        end
        pv[i] = ov[i];
        ps[i] = osv[i];
      end
    end
    prev_or = out_ready;
  end

  task automatic send(input logic [127:0] s, input logic d,
                      input logic [127:0] e);
    exp_t x;
    int n;
    n = 0;
    while (rdy != 3'b111 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (rdy != 3'b111) begin
      fail("wait_in_ready");
      return;
    end
    in_valid = 1'b1;
    in_state = s;
    in_dir   = d;
    @(posedge clk); #1;
    x.d = e;
    x.t = cyc;
    for (int i = 0; i < 3; i++) q[i].push_back(x);
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_dir   = ~d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if ((q[0].size() + q[1].size() + q[2].size()) != 0) fail("drain");
  endtask

  initial begin
    logic [127:0] s;
    logic         d;
    int           n;
    build_tables();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_dir   = 1'b0;
    in_state = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", 128'(rdy[i]), 128'(1));
      chk("rst_out_valid", 128'(ov[i]), 128'(0));
      chk("rst_out_state", osv[i], 128'(0));
    end
    reset_n = 1'b1;
    @(posedge clk); #1;

    or_mode = 1;
    send(KAT_IN, 1'b0, KAT_OUT);
    send(KAT_OUT, 1'b1, KAT_IN);
    send({16{8'h00}}, 1'b0, {16{8'h63}});
    send({16{8'hff}}, 1'b0, {16{8'h16}});
    send({16{8'h63}}, 1'b1, {16{8'h00}});
    send({16{8'h53}}, 1'b0, {16{8'hed}});
    drain();

    or_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    s = {$urandom, $urandom, $urandom, $urandom};
    send(s, 1'b0, ref_sub(s, 1'b0));
    in_valid = 1'b1;
    n = 0;
    while (ov != 3'b111 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (ov != 3'b111) fail("bp_wait_valid");
    repeat (10) @(posedge clk);
    #1;
    in_valid = 1'b0;
    or_mode = 1;
    drain();

    or_mode = 2;
    repeat (30) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      d = 1'($urandom_range(0, 1));
      send(s, d, ref_sub(s, d));
    end
    or_mode = 1;
    drain();

    or_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send(KAT_IN, 1'b0, KAT_OUT);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_in_ready", 128'(rdy[0]), 128'(1));
    chk("midrst_out_valid", 128'(ov[0]), 128'(0));
    chk("midrst_out_state", os0, 128'(0));
    chk("midrst_l16_valid", 128'(ov[2]), 128'(0));
    for (int i = 0; i < 3; i++) q[i].delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    or_mode = 1;
    repeat (20) @(posedge clk);
    #1;
    chk("postrst_no_valid", 128'(ov), 128'(0));
    send(KAT_IN, 1'b0, KAT_OUT);
    drain();

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
